// File: rtl/shift_reg_step_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : shift_reg_step_if
// Description : Bus bundle for the stepped universal shift register. The
//               master side drives the divided step clock, the operation
//               select and the data inputs; the slave side returns the
//               registered register contents and step status.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface shift_reg_step_if #(
  parameter int WIDTH = 8
) ();

  logic             step_clk;
  logic [2:0]       mode;
  logic [WIDTH-1:0] load_val;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             step_pulse;
  logic [7:0]       step_cnt;

  // Stimulus side: drives step clock, operation and data in.
  modport master (
    output step_clk,
    output mode,
    output load_val,
    output ser_in,
    input  q,
    input  ser_out,
    input  step_pulse,
    input  step_cnt
  );

  // Register side: consumes step clock, operation and data, returns state.
  modport slave (
    input  step_clk,
    input  mode,
    input  load_val,
    input  ser_in,
    output q,
    output ser_out,
    output step_pulse,
    output step_cnt
  );

endinterface
`default_nettype wire

// File: rtl/shift_reg_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : shift_reg_step
// Description : Universal shift register advancing one operation per rising
//               edge of a slow divided clock. The divided clock is treated as
//               asynchronous data: synchronized, edge-detected and turned
//               into a one-cycle enable in the clk_in domain.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module shift_reg_step #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic          clk_in,
  input  wire logic          rst,
  shift_reg_step_if.slave    bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] c_MODE_HOLD = 3'b000;
  localparam logic [2:0] c_MODE_SHL  = 3'b001;
  localparam logic [2:0] c_MODE_SHR  = 3'b010;
  localparam logic [2:0] c_MODE_ROL  = 3'b011;
  localparam logic [2:0] c_MODE_ROR  = 3'b100;
  localparam logic [2:0] c_MODE_LOAD = 3'b101;
  localparam logic [2:0] c_MODE_JOHN = 3'b110;
  localparam logic [2:0] c_MODE_CLR  = 3'b111;

  // --------------------------------------------------------------------------
  // Step clock synchronizer and edge detector
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] w_sync_d;
  logic                   r_prev;
  logic                   w_step;
  logic                   r_step_en;

  assign w_sync_d[0] = bus.step_clk;

  generate
    for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_sync
      assign w_sync_d[i] = r_sync[i-1];
    end
  endgenerate

  // Synchronizer chain and edge history; reset high so a step clock that is
  // already high when reset releases never looks like a rising edge.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= w_sync_d;
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_step = r_sync[SYNC_STAGES-1] & ~r_prev;

  // Register the detected edge so the operation executes one cycle later;
  // reset drops any step that is still pending.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_step_en <= 1'b0;
    end else begin
      r_step_en <= w_step;
    end
  end

  // --------------------------------------------------------------------------
  // Register datapath
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_q;
  logic             r_ser;
  logic [7:0]       r_cnt;
  logic             r_pulse;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_ser_nxt;
  logic [7:0]       w_cnt_nxt;

  // Next-state selection; everything holds unless this is the step cycle.
  always_comb begin
    w_q_nxt   = r_q;
    w_ser_nxt = r_ser;
    w_cnt_nxt = r_cnt;
    if (r_step_en) begin
      case (bus.mode)
        c_MODE_HOLD: begin
          w_q_nxt = r_q;
        end
        c_MODE_SHL: begin
          w_q_nxt   = {r_q[MSB-1:0], bus.ser_in};
          w_ser_nxt = r_q[MSB];
          w_cnt_nxt = r_cnt + 8'd1;
        end
        c_MODE_SHR: begin
          w_q_nxt   = {bus.ser_in, r_q[MSB:1]};
          w_ser_nxt = r_q[0];
          w_cnt_nxt = r_cnt + 8'd1;
        end
        c_MODE_ROL: begin
          w_q_nxt   = {r_q[MSB-1:0], r_q[MSB]};
          w_ser_nxt = r_q[MSB];
          w_cnt_nxt = r_cnt + 8'd1;
        end
        c_MODE_ROR: begin
          w_q_nxt   = {r_q[0], r_q[MSB:1]};
          w_ser_nxt = r_q[0];
          w_cnt_nxt = r_cnt + 8'd1;
        end
        c_MODE_LOAD: begin
          w_q_nxt   = bus.load_val;
          w_cnt_nxt = r_cnt + 8'd1;
        end
        c_MODE_JOHN: begin
          w_q_nxt   = {r_q[MSB-1:0], ~r_q[MSB]};
          w_ser_nxt = r_q[MSB];
          w_cnt_nxt = r_cnt + 8'd1;
        end
        c_MODE_CLR: begin
          w_q_nxt   = '0;
          w_ser_nxt = 1'b0;
          w_cnt_nxt = '0;
        end
        default: begin
          w_q_nxt = r_q;
        end
      endcase
    end
  end

  // State and status registers; the pulse marks the cycle after execution.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_q     <= '0;
      r_ser   <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_ser   <= w_ser_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= r_step_en;
    end
  end

  assign bus.q          = r_q;
  assign bus.ser_out    = r_ser;
  assign bus.step_cnt   = r_cnt;
  assign bus.step_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_shift_reg_step
// Description : Self-checking bench for shift_reg_step: directed vector table
//               plus hand-written reset, wrap and long-pulse sequences.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_shift_reg_step;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_JOHN = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] load_val;
    logic       ser_in;
    logic [7:0] exp_q;
    logic       exp_ser;
    logic [7:0] exp_cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   pulse_cnt;

  shift_reg_step_if #(.WIDTH(8)) bus ();

  shift_reg_step #(
    .WIDTH      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in(clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which step_pulse is seen high.
  always @(negedge clk) begin
    if (bus.step_pulse === 1'b1) pulse_cnt = pulse_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Raise step_clk, wait for the pulse, check latency and pulse width, then
  // return step_clk low and scramble the inputs to show they are ignored.
  task automatic do_step(input logic [2:0] m, input logic [7:0] lv, input logic si);
    int lat;
    bit seen;
    bus.mode     = m;
    bus.load_val = lv;
    bus.ser_in   = si;
    bus.step_clk = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat = lat + 1;
      if (bus.step_pulse === 1'b1) seen = 1'b1;
    end
    check("step_latency", lat, seen ? 4 : 99);
    @(negedge clk);
    check("pulse_width", {31'd0, bus.step_pulse}, 0);
    bus.step_clk = 1'b0;
    bus.mode     = M_LOAD;
    bus.load_val = 8'hEE;
    bus.ser_in   = ~si;
    repeat (5) @(negedge clk);
  endtask

  task automatic check_state(input string nm, input logic [7:0] q, input logic s, input logic [7:0] c);
    check({nm, ".q"}, bus.q, q);
    check({nm, ".ser_out"}, {31'd0, bus.ser_out}, {31'd0, s});
    check({nm, ".step_cnt"}, bus.step_cnt, c);
  endtask

  vec_t vq[$];
  logic [7:0] jv[16];
  int p0;

  initial begin
    n_vec = 0;
    n_err = 0;
    pulse_cnt = 0;
    jv = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
           8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

    // Directed vector table: {mode, load_val, ser_in, exp q, exp ser_out, exp cnt}
    vq.push_back('{M_LOAD, 8'h81, 1'b0, 8'h81, 1'b0, 8'd1});
    vq.push_back('{M_ROL,  8'h00, 1'b0, 8'h03, 1'b1, 8'd2});
    vq.push_back('{M_ROR,  8'h00, 1'b0, 8'h81, 1'b1, 8'd3});
    vq.push_back('{M_SHL,  8'h00, 1'b0, 8'h02, 1'b1, 8'd4});
    vq.push_back('{M_SHR,  8'h00, 1'b1, 8'h81, 1'b0, 8'd5});
    vq.push_back('{M_HOLD, 8'hFF, 1'b1, 8'h81, 1'b0, 8'd5});
    vq.push_back('{M_CLR,  8'hFF, 1'b1, 8'h00, 1'b0, 8'd0});
    vq.push_back('{M_SHR,  8'h00, 1'b1, 8'h80, 1'b0, 8'd1});
    vq.push_back('{M_SHR,  8'h00, 1'b1, 8'hC0, 1'b0, 8'd2});
    vq.push_back('{M_SHR,  8'h00, 1'b1, 8'hE0, 1'b0, 8'd3});
    vq.push_back('{M_SHR,  8'h00, 1'b1, 8'hF0, 1'b0, 8'd4});
    vq.push_back('{M_SHR,  8'h00, 1'b1, 8'hF8, 1'b0, 8'd5});
    vq.push_back('{M_SHR,  8'h00, 1'b1, 8'hFC, 1'b0, 8'd6});
    vq.push_back('{M_SHR,  8'h00, 1'b1, 8'hFE, 1'b0, 8'd7});
    vq.push_back('{M_SHR,  8'h00, 1'b1, 8'hFF, 1'b0, 8'd8});
    vq.push_back('{M_CLR,  8'h00, 1'b0, 8'h00, 1'b0, 8'd0});
    for (int i = 0; i < 16; i++) begin
      vq.push_back('{M_JOHN, 8'h00, 1'b0, jv[i], (i >= 8) ? 1'b1 : 1'b0, 8'(i + 1)});
    end
    vq.push_back('{M_JOHN, 8'h00, 1'b0, 8'h01, 1'b0, 8'd17});
    vq.push_back('{M_LOAD, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'd18});
    vq.push_back('{M_SHL,  8'h00, 1'b1, 8'h4B, 1'b1, 8'd19});

    // Reset with step_clk held high: no spurious step after release.
    rst          = 1'b1;
    bus.step_clk = 1'b1;
    bus.mode     = M_LOAD;
    bus.load_val = 8'h55;
    bus.ser_in   = 1'b1;
    repeat (5) @(negedge clk);
    check_state("reset", 8'h00, 1'b0, 8'd0);
    check("reset.step_pulse", {31'd0, bus.step_pulse}, 0);
    rst = 1'b0;
    p0  = pulse_cnt;
    repeat (20) @(negedge clk);
    check("no_spurious_pulse", pulse_cnt - p0, 0);
    check("no_spurious.q", bus.q, 8'h00);
    bus.step_clk = 1'b0;
    repeat (5) @(negedge clk);

    // First genuine edge: a hold step, pulse fires, state stays.
    p0 = pulse_cnt;
    do_step(M_HOLD, 8'hFF, 1'b1);
    check("first_step.pulses", pulse_cnt - p0, 1);
    check_state("first_hold", 8'h00, 1'b0, 8'd0);

    // Table-driven vectors.
    foreach (vq[i]) begin
      p0 = pulse_cnt;
      do_step(vq[i].mode, vq[i].load_val, vq[i].ser_in);
      check($sformatf("vec%0d.pulses", i), pulse_cnt - p0, 1);
      check_state($sformatf("vec%0d", i), vq[i].exp_q, vq[i].exp_ser, vq[i].exp_cnt);
    end

    // Counter wrap: 255 steps then one more.
    do_step(M_CLR, 8'h00, 1'b0);
    check("wrap_clear.cnt", bus.step_cnt, 8'd0);
    for (int i = 0; i < 255; i++) do_step(M_SHL, 8'h00, 1'b0);
    check("wrap.cnt255", bus.step_cnt, 8'd255);
    do_step(M_SHL, 8'h00, 1'b0);
    check("wrap.cnt0", bus.step_cnt, 8'd0);

    // Clear after non-zero state, then hold leaves state alone.
    do_step(M_LOAD, 8'hC3, 1'b0);
    do_step(M_ROL, 8'h00, 1'b0);
    check_state("pre_clear", 8'h87, 1'b1, 8'd2);
    do_step(M_CLR, 8'h00, 1'b0);
    check_state("clear", 8'h00, 1'b0, 8'd0);
    do_step(M_LOAD, 8'h96, 1'b0);
    p0 = pulse_cnt;
    do_step(M_HOLD, 8'h00, 1'b1);
    check("hold.pulses", pulse_cnt - p0, 1);
    check_state("hold", 8'h96, 1'b0, 8'd1);

    // Reset arriving on the very edge a step would execute.
    bus.mode     = M_LOAD;
    bus.load_val = 8'h5A;
    bus.step_clk = 1'b1;
    p0 = pulse_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_state("rst_collide", 8'h00, 1'b0, 8'd0);
    check("rst_collide.step_pulse", {31'd0, bus.step_pulse}, 0);
    repeat (10) @(negedge clk);
    check("rst_collide.pulses", pulse_cnt - p0, 0);
    check("rst_collide.q_after", bus.q, 8'h00);
    bus.step_clk = 1'b0;
    repeat (5) @(negedge clk);

    // Long high on step_clk produces exactly one step.
    bus.mode   = M_SHR;
    bus.ser_in = 1'b1;
    bus.step_clk = 1'b1;
    p0 = pulse_cnt;
    repeat (1000) @(negedge clk);
    check("long_high.pulses", pulse_cnt - p0, 1);
    check_state("long_high", 8'h80, 1'b0, 8'd1);
    bus.step_clk = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_reg_step.md
Name: shift_reg_step

Overview:
- Universal shift register that advances one operation per rising edge of the divided step clock (1 Hz class) from the clock divider.
- Runs entirely on the board clock clk_in. The divided clock enters only as data: it is synchronized, edge-detected and turned into a one-cycle step enable.
- Outputs drive the LED bank and the serial chain of the shift-register demo.

Parameters:
- WIDTH, 8, register width in bits (legal range ≥ 2).
- SYNC_STAGES, 2, number of synchronizer flops on step_clk (legal range ≥ 2).

Ports:
- clk_in  input  1  board clock; all flops on its rising edge.
- rst  input  1  synchronous, active-high reset.
- step_clk  input  1  divided clock from the divider. Treated as asynchronous data, never used as a clock.
- mode  input  3  operation, sampled only on a step.
- load_val  input  WIDTH  parallel load value.
- ser_in  input  1  serial input bit.
- q  output  WIDTH  register contents.
- ser_out  output  1  last bit shifted or rotated out.
- step_pulse  output  1  high for exactly one clk_in cycle after each executed step.
- step_cnt  output  8  count of executed non-hold steps.

Behaviour:
- Interface: one clock, clk_in. Reset is synchronous and active-high on rst.
- Reset values:
  - q=0, ser_out=0, step_cnt=0, step_pulse=0.
  - All synchronizer flops and the edge-history flop are reset to 1. A step_clk that is high at reset release therefore causes no step; only a genuine 0→1 transition after reset does.
- Synchronizer:
  - sync[0] samples step_clk; sync[i] samples sync[i-1].
  - prev samples sync[SYNC_STAGES-1].
  - Internal step = sync[last] & ~prev.
- Latency:
  - step_clk first sampled high at edge k → q, ser_out, step_cnt and step_pulse update at edge k+SYNC_STAGES+1 (edge k+3 at default).
  - step_pulse drops on the next edge.
- One step per step_clk rising edge, regardless of how long step_clk stays high. A step_clk high pulse narrower than one clk_in period may be missed; this is acceptable.
- Operations on step (mode sampled in the step cycle; MSB = WIDTH-1):
  - 000 hold: nothing changes, step_cnt unchanged. step_pulse still fires.
  - 001 shift left: q <= {q[MSB-1:0], ser_in}; ser_out <= old q[MSB].
  - 010 shift right: q <= {ser_in, q[MSB:1]}; ser_out <= old q[0].
  - 011 rotate left: q <= {q[MSB-1:0], q[MSB]}; ser_out <= old q[MSB].
  - 100 rotate right: q <= {q[0], q[MSB:1]}; ser_out <= old q[0].
  - 101 load: q <= load_val; ser_out unchanged.
  - 110 Johnson: q <= {q[MSB-1:0], ~q[MSB]}; ser_out <= old q[MSB]. Period is 2*WIDTH steps.
  - 111 clear: q <= 0; ser_out <= 0; step_cnt <= 0.
- step_cnt:
  - Increments by 1 on every step with mode 001–110.
  - Wraps 255→0 with no flag.
- Between steps, q, ser_out and step_cnt hold. Changes to mode, load_val or ser_in have no effect outside the step cycle.
- rst asserted mid-operation, including in the same cycle as a step: reset wins. All outputs and sync flops take their reset values at that edge, and the pending step is discarded.
- Outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset/no spurious step: hold step_clk=1 through reset and release → no step_pulse, q=0 for 20 cycles. Drive step_clk 0 then 1 → exactly one step_pulse, 3 cycles after step_clk is first sampled high.
- Load then rotate left:
  - mode=101, load_val=8'b1000_0001, one step → q=0x81, step_cnt=1.
  - mode=011, one step → q=0x03, ser_out=1, step_cnt=2.
- Shift right with ser_in=1 from q=0: 8 steps → q=0xFF. step_cnt increments once per step and step_pulse asserts once per step.
- Johnson from q=0: 16 steps → sequence 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00. Then repeats.
- Wrap and clear:
  - 256 non-hold steps → step_cnt=0 with no glitch.
  - mode=111 step → q=0, ser_out=0, step_cnt=0.
  - mode=000 step → step_pulse fires, state unchanged.
- Reset collision and long high:
  - Assert rst on the same edge a step would execute → q and step_cnt stay at reset values.
  - Hold step_clk high for 1000 cycles → exactly one step.
